reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 12 +
 rtl/reg_bank_clr_fsm.sv | 59 +++++
 rtl/reg_bank.sv | 104 ++++++++++
 tb/tb_reg_bank.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the reg_bank register file and its clear sequencer.
package reg_bank_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefDepth     = 4;

  typedef enum logic {
    IDLE,
    SWEEP
  } clr_state_e;

endpackage

// File: rtl/reg_bank_clr_fsm.sv
// Clear sequencer: on CLR_REQ walks every entry index once, one per cycle, while BUSY is high.
module reg_bank_clr_fsm
  import reg_bank_pkg::*;
#(
  parameter  int unsigned DEPTH      = DefDepth,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR_REQ,
  output logic                  BUSY,
  output logic                  CLR_STB,
  output logic [ADDR_WIDTH-1:0] CLR_IDX
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (CLR_REQ) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        // DEPTH is a power of two, so the counter wraps back to 0 on the last entry.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY    = (state_q == SWEEP);
  assign CLR_STB = BUSY;
  assign CLR_IDX = cnt_q;

endmodule

// File: rtl/reg_bank.sv
// Register file with one write port, two registered read ports and a per-entry valid bit.
// Define REG_BANK_BYPASS_EN for write-first read/write collisions; default is read-first.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DefDataWidth,
  parameter  int unsigned DEPTH      = DefDepth,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR_A,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR_B,
  output logic [DATA_WIDTH-1:0] RD_DATA_A,
  output logic [DATA_WIDTH-1:0] RD_DATA_B,
  output logic                  RD_VALID_A,
  output logic                  RD_VALID_B,
  input  logic                  CLR_REQ,
  output logic                  BUSY
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;

  logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic                  rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;

  logic                  clr_stb;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  wr_acc;

  reg_bank_clr_fsm #(
    .DEPTH (DEPTH)
  ) u_clr_fsm (
    .CLK     (CLK),
    .RST     (RST),
    .CLR_REQ (CLR_REQ),
    .BUSY    (BUSY),
    .CLR_STB (clr_stb),
    .CLR_IDX (clr_idx)
  );

  // Writes are only dropped while a sweep is running, so they never race the clear strobe.
  assign wr_acc = WR_EN && !BUSY;

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (wr_acc) begin
      mem_d[WR_ADDR]   = WR_DATA;
      valid_d[WR_ADDR] = 1'b1;
    end
    if (clr_stb) begin
      mem_d[clr_idx]   = '0;
      valid_d[clr_idx] = 1'b0;
    end
  end

  always_comb begin
    rd_data_a_d  = mem_q[RD_ADDR_A];
    rd_valid_a_d = valid_q[RD_ADDR_A];
    rd_data_b_d  = mem_q[RD_ADDR_B];
    rd_valid_b_d = valid_q[RD_ADDR_B];
`ifdef REG_BANK_BYPASS_EN
    if (wr_acc && (WR_ADDR == RD_ADDR_A)) begin
      rd_data_a_d  = WR_DATA;
      rd_valid_a_d = 1'b1;
    end
    if (wr_acc && (WR_ADDR == RD_ADDR_B)) begin
      rd_data_b_d  = WR_DATA;
      rd_valid_b_d = 1'b1;
    end
`else
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_q        <= '{default: '0};
      valid_q      <= '0;
      rd_data_a_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_data_b_q  <= '0;
      rd_valid_b_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      valid_q      <= valid_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_b_q <= rd_valid_b_d;
    end
  end

  assign RD_DATA_A  = rd_data_a_q;
  assign RD_VALID_A = rd_valid_a_q;
  assign RD_DATA_B  = rd_data_b_q;
  assign RD_VALID_B = rd_valid_b_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank at the default 8-bit x 4-entry size.
module tb_reg_bank;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b;
  logic       clr_req;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  reg_bank #(
    .DATA_WIDTH (8),
    .DEPTH      (4)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .WR_EN      (wr_en),
    .WR_ADDR    (wr_addr),
    .WR_DATA    (wr_data),
    .RD_ADDR_A  (rd_addr_a),
    .RD_ADDR_B  (rd_addr_b),
    .RD_DATA_A  (rd_data_a),
    .RD_DATA_B  (rd_data_b),
    .RD_VALID_A (rd_valid_a),
    .RD_VALID_B (rd_valid_b),
    .CLR_REQ    (clr_req),
    .BUSY       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
    step();
    step();
    tests_run++;
    if ({rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy} !== 19'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got A=%h/%b B=%h/%b busy=%b, want all 0",
               rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5;
    step();
    wr_en = 1'b0; rd_addr_a = 2'd2; rd_addr_b = 2'd1;
    step();
    tests_run++;
    if ({rd_data_a, rd_valid_a} !== {8'hA5, 1'b1}) begin
      tests_failed++;
      $display("FAIL write_read_a: got %h/%b, want a5/1", rd_data_a, rd_valid_a);
    end
    tests_run++;
    if ({rd_data_b, rd_valid_b} !== {8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL unwritten_b: got %h/%b, want 00/0", rd_data_b, rd_valid_b);
    end
  endtask

  task automatic test_dual_read();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h11;
    step();
    wr_addr = 2'd3; wr_data = 8'h22;
    step();
    wr_en = 1'b0; rd_addr_a = 2'd0; rd_addr_b = 2'd3;
    step();
    tests_run++;
    if ({rd_data_a, rd_valid_a, rd_data_b, rd_valid_b} !== {8'h11, 1'b1, 8'h22, 1'b1}) begin
      tests_failed++;
      $display("FAIL dual_read: got A=%h/%b B=%h/%b, want A=11/1 B=22/1",
               rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_d;
    logic       exp_v;
`ifdef REG_BANK_BYPASS_EN
    exp_d = 8'h3C; exp_v = 1'b1;
`else
    exp_d = 8'h00; exp_v = 1'b0;
`endif
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h3C; rd_addr_a = 2'd1;
    step();
    wr_en = 1'b0;
    tests_run++;
    if ({rd_data_a, rd_valid_a} !== {exp_d, exp_v}) begin
      tests_failed++;
      $display("FAIL collision: got %h/%b, want %h/%b", rd_data_a, rd_valid_a, exp_d, exp_v);
    end
    step();
    tests_run++;
    if ({rd_data_a, rd_valid_a} !== {8'h3C, 1'b1}) begin
      tests_failed++;
      $display("FAIL after_collision: got %h/%b, want 3c/1", rd_data_a, rd_valid_a);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = 8'(8'h10 + i);
      step();
    end
    wr_en = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_before_clear: got %b, want 0", busy);
    end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_cycle%0d: got %b, want 1", i, busy);
      end
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
      clr_req = (i == 1);
      step();
      clr_req = 1'b0;
    end
    wr_en = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_after_sweep: got %b, want 0", busy);
    end
    step();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_restart: got busy %b, want 0", busy);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i); rd_addr_b = 2'(i);
      step();
      tests_run++;
      if ({rd_data_a, rd_valid_a, rd_data_b, rd_valid_b} !== 18'h0) begin
        tests_failed++;
        $display("FAIL cleared_entry%0d: got A=%h/%b B=%h/%b, want 00/0",
                 i, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
      end
    end
  endtask

  task automatic test_write_and_clear();
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h77; clr_req = 1'b1; rd_addr_a = 2'd3;
    step();
    wr_en = 1'b0; clr_req = 1'b0;
    // Entry 3 is wiped on the fourth sweep edge; the read pipeline shows it one edge later.
    for (int k = 1; k <= 4; k++) begin
      step();
      tests_run++;
      if ({rd_data_a, rd_valid_a} !== {8'h77, 1'b1}) begin
        tests_failed++;
        $display("FAIL wr_clr_hold%0d: got %h/%b, want 77/1", k, rd_data_a, rd_valid_a);
      end
    end
    step();
    tests_run++;
    if ({rd_data_a, rd_valid_a, busy} !== {8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL wr_clr_cleared: got %h/%b busy=%b, want 00/0 busy=0",
               rd_data_a, rd_valid_a, busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h5A;
    step();
    wr_en = 1'b0; rd_addr_a = 2'd2; rd_addr_b = 2'd2; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    tests_run++;
    if ({rd_data_a, rd_valid_a, busy} !== {8'h5A, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL pre_abort: got %h/%b busy=%b, want 5a/1 busy=1", rd_data_a, rd_valid_a, busy);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy} !== 19'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got A=%h/%b B=%h/%b busy=%b, want all 0",
               rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy);
    end
    step();
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if ({busy, rd_data_a, rd_valid_a} !== 10'h0) begin
      tests_failed++;
      $display("FAIL post_release: got busy=%b A=%h/%b, want busy=0 A=00/0",
               busy, rd_data_a, rd_valid_a);
    end
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h42;
    step();
    wr_en = 1'b0; rd_addr_a = 2'd1;
    step();
    tests_run++;
    if ({rd_data_a, rd_valid_a} !== {8'h42, 1'b1}) begin
      tests_failed++;
      $display("FAIL post_reset_rw: got %h/%b, want 42/1", rd_data_a, rd_valid_a);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dual_read();
    test_collision();
    test_clear();
    test_write_and_clear();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
